// File: rtl/x_ramb_pkg.sv
// Shared definitions for the parametrised single-port block-RAM model.
package x_ramb_pkg;

  typedef enum int unsigned {
    WM_WRITE_FIRST = 0,
    WM_READ_FIRST  = 1,
    WM_NO_CHANGE   = 2
  } write_mode_e;

  function automatic int unsigned lane_count(input int unsigned data_width,
                                             input int unsigned lane_width);
    return data_width / lane_width;
  endfunction

endpackage

// File: rtl/x_ramb_out_stage.sv
// Optional output register stage with clock enable, sync set/reset and valid pipe.
module x_ramb_out_stage
  import x_ramb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_regce,
  input  logic                  i_ssr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // Output register: loads the latch (or SRVAL under SSR) when REGCE is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= SRVAL;
      r_valid <= 1'b0;
    end else if (i_regce) begin
      if (i_ssr) begin
        r_data  <= SRVAL;
        r_valid <= 1'b0;
      end else begin
        r_data  <= i_data;
        r_valid <= i_valid;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/x_ramb_sp_param_int.sv
// Parametrised single-port block RAM: byte-lane writes, selectable write mode,
// optional output register.
module x_ramb_sp_param_int
  import x_ramb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           LANE_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           WRITE_MODE = 0,
  parameter int unsigned           DO_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD  = '0
) (
  input  logic                                            CLK,
  input  logic                                            RST_N,
  input  logic                                            EN,
  input  logic                                            SSR,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0]   WE,
  input  logic [ADDR_WIDTH-1:0]                           ADDR,
  input  logic [DATA_WIDTH-1:0]                           DI,
  input  logic                                            REGCE,
  output logic [DATA_WIDTH-1:0]                           DO,
  output logic                                            DO_VALID
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: INIT_WORD};

  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_any_we;
  logic [DATA_WIDTH-1:0] r_latch;
  logic                  r_lvalid;
  logic [DATA_WIDTH-1:0] w_do;
  logic                  w_do_valid;

  assign w_old    = r_mem[ADDR];
  assign w_any_we = |WE;

  // Word as it will look after this edge's lane writes.
  always_comb begin
    w_merged = w_old;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (WE[i]) begin
        w_merged[i*LANE_WIDTH +: LANE_WIDTH] = DI[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Storage update; whole merged word written, which equals per-lane writes.
  always_ff @(posedge CLK) begin
    if (RST_N && EN && w_any_we) begin
      r_mem[ADDR] <= w_merged;
    end
  end

  // Read latch and its valid flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_latch  <= SRVAL;
      r_lvalid <= 1'b0;
    end else if (EN) begin
      if (SSR && (DO_REG == 0)) begin
        r_latch <= SRVAL;
      end else if (w_any_we) begin
        if (WRITE_MODE == WM_WRITE_FIRST) begin
          r_latch <= w_merged;
        end else if (WRITE_MODE == WM_READ_FIRST) begin
          r_latch <= w_old;
        end
      end else begin
        r_latch <= w_old;
      end

      if (SSR) begin
        r_lvalid <= 1'b0;
      end else if (!((WRITE_MODE == WM_NO_CHANGE) && w_any_we)) begin
        r_lvalid <= 1'b1;
      end
    end
  end

  if (DO_REG != 0) begin : g_do_reg
    x_ramb_out_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .SRVAL      (SRVAL)
    ) u_out_stage (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_regce (REGCE),
      .i_ssr   (SSR),
      .i_data  (r_latch),
      .i_valid (r_lvalid),
      .o_data  (w_do),
      .o_valid (w_do_valid)
    );
  end else begin : g_no_reg
    logic w_unused_regce;
    assign w_unused_regce = REGCE;
    assign w_do           = r_latch;
    assign w_do_valid     = r_lvalid;
  end

  assign DO       = w_do;
  assign DO_VALID = w_do_valid;

endmodule

// File: tb/tb_x_ramb_sp_param_int.sv
// Bench: four configurations share one stimulus stream; a per-instance
// behavioural model is compared every cycle, plus literal expectations.
module tb_x_ramb_sp_param_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        ssr = 1'b0;
  logic [1:0]  we = '0;
  logic [3:0]  addr = '0;
  logic [15:0] di = '0;
  logic        regce = 1'b0;

  logic [15:0] do_wf, do_rf, do_nc, do_dr;
  logic        dv_wf, dv_rf, dv_nc, dv_dr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: write-first, 1: read-first, 2: no-change, 3: write-first + output register
  x_ramb_sp_param_int #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(0),
    .DO_REG(0), .SRVAL(16'h5A5A), .INIT_WORD(16'h0000)) u_wf (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .REGCE(regce), .DO(do_wf), .DO_VALID(dv_wf));

  x_ramb_sp_param_int #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(1),
    .DO_REG(0), .SRVAL(16'hC3C3), .INIT_WORD(16'h1111)) u_rf (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .REGCE(regce), .DO(do_rf), .DO_VALID(dv_rf));

  x_ramb_sp_param_int #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(2),
    .DO_REG(0), .SRVAL(16'h0F0F), .INIT_WORD(16'h0000)) u_nc (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .REGCE(regce), .DO(do_nc), .DO_VALID(dv_nc));

  x_ramb_sp_param_int #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE(0),
    .DO_REG(1), .SRVAL(16'h005A), .INIT_WORD(16'h0000)) u_dr (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .REGCE(regce), .DO(do_dr), .DO_VALID(dv_dr));

  // Model configuration, one entry per instance above.
  localparam logic [15:0] C_SRV   [4] = '{16'h5A5A, 16'hC3C3, 16'h0F0F, 16'h005A};
  localparam logic [15:0] C_INI   [4] = '{16'h0000, 16'h1111, 16'h0000, 16'h0000};
  localparam int          C_MODE  [4] = '{0, 1, 2, 0};
  localparam bit          C_DOREG [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [15:0] m_mem [4][16];
  logic [15:0] m_lat [4];
  logic [15:0] m_or  [4];
  logic        m_lv  [4];
  logic        m_ov  [4];
  logic [15:0] m_old, m_mrg;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_do(input int k);
    case (k)
      0:       return do_wf;
      1:       return do_rf;
      2:       return do_nc;
      default: return do_dr;
    endcase
  endfunction

  function automatic logic dut_dv(input int k);
    case (k)
      0:       return dv_wf;
      1:       return dv_rf;
      2:       return dv_nc;
      default: return dv_dr;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < 16; a++) m_mem[k][a] = C_INI[k];
      m_lat[k] = C_SRV[k];
      m_or[k]  = C_SRV[k];
      m_lv[k]  = 1'b0;
      m_ov[k]  = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      m_lat[k] = C_SRV[k];
      m_or[k]  = C_SRV[k];
      m_lv[k]  = 1'b0;
      m_ov[k]  = 1'b0;
    end
  end

  // Behavioural model: what each edge must do to storage, latch and output register.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_old = m_mem[k][addr];
        m_mrg = m_old;
        if (we[0]) m_mrg[7:0]  = di[7:0];
        if (we[1]) m_mrg[15:8] = di[15:8];
        if (C_DOREG[k] && regce) begin
          m_or[k] = ssr ? C_SRV[k] : m_lat[k];
          m_ov[k] = ssr ? 1'b0 : m_lv[k];
        end
        if (en) begin
          if (ssr && !C_DOREG[k]) m_lat[k] = C_SRV[k];
          else if (we != 2'b00) begin
            if (C_MODE[k] == 0) m_lat[k] = m_mrg;
            else if (C_MODE[k] == 1) m_lat[k] = m_old;
          end else m_lat[k] = m_old;
          if (ssr) m_lv[k] = 1'b0;
          else if (!(C_MODE[k] == 2 && we != 2'b00)) m_lv[k] = 1'b1;
          m_mem[k][addr] = m_mrg;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("model_do[%0d]", k), dut_do(k), C_DOREG[k] ? m_or[k] : m_lat[k]);
      chk($sformatf("model_valid[%0d]", k), {15'd0, dut_dv(k)},
          {15'd0, (C_DOREG[k] ? m_ov[k] : m_lv[k])});
    end
  end

  task automatic step(input logic s_en, input logic s_ssr, input logic [1:0] s_we,
                      input logic [3:0] s_a, input logic [15:0] s_d, input logic s_rce);
    en = s_en; ssr = s_ssr; we = s_we; addr = s_a; di = s_d; regce = s_rce;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_wf_do", do_wf, 16'h5A5A);
    chk("reset_wf_valid", {15'd0, dv_wf}, 16'h0000);
    chk("reset_dr_do", do_dr, 16'h005A);
    chk("reset_dr_valid", {15'd0, dv_dr}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);

    // Write-first write then read
    step(1'b1, 1'b0, 2'b11, 4'd3, 16'h00A5, 1'b1);
    chk("wf_write_do", do_wf, 16'h00A5);
    chk("wf_write_valid", {15'd0, dv_wf}, 16'h0001);
    chk("dr_lat1_do", do_dr, 16'h005A);
    chk("nc_write_valid", {15'd0, dv_nc}, 16'h0000);
    step(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b1);
    chk("wf_read_do", do_wf, 16'h00A5);
    chk("dr_lat2_do", do_dr, 16'h00A5);
    chk("dr_lat2_valid", {15'd0, dv_dr}, 16'h0001);

    // Read-first
    step(1'b1, 1'b0, 2'b11, 4'd0, 16'h0022, 1'b1);
    chk("rf_write_do", do_rf, 16'h1111);
    step(1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
    chk("rf_read_do", do_rf, 16'h0022);

    // No-change with partial lane write
    step(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1);
    chk("nc_read_init", do_nc, 16'h0000);
    step(1'b1, 1'b0, 2'b10, 4'd5, 16'hBEEF, 1'b1);
    chk("nc_write_hold", do_nc, 16'h0000);
    chk("nc_write_hold_valid", {15'd0, dv_nc}, 16'h0001);
    step(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1);
    chk("nc_lane_read", do_nc, 16'hBE00);
    chk("rf_lane_read", do_rf, 16'hBE11);

    // Output register latency and REGCE stall
    step(1'b1, 1'b0, 2'b11, 4'd2, 16'h0077, 1'b1);
    step(1'b1, 1'b0, 2'b00, 4'd9, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 2'b00, 4'd2, 16'h0000, 1'b1);
    chk("dr_t0_do", do_dr, 16'h0000);
    step(1'b0, 1'b0, 2'b00, 4'd2, 16'h0000, 1'b0);
    chk("dr_regce_stall", do_dr, 16'h0000);
    step(1'b0, 1'b0, 2'b00, 4'd2, 16'h0000, 1'b1);
    chk("dr_t2_do", do_dr, 16'h0077);
    chk("dr_t2_valid", {15'd0, dv_dr}, 16'h0001);

    // EN=0 blocks SSR
    step(1'b0, 1'b1, 2'b00, 4'd2, 16'h0000, 1'b0);
    chk("en0_ssr_do", do_wf, 16'h0077);
    chk("en0_ssr_valid", {15'd0, dv_wf}, 16'h0001);

    // SSR with output register: outreg reset, latch keeps read data but loses valid
    step(1'b1, 1'b1, 2'b00, 4'd2, 16'h0000, 1'b1);
    chk("dr_ssr_do", do_dr, 16'h005A);
    chk("dr_ssr_valid", {15'd0, dv_dr}, 16'h0000);
    step(1'b0, 1'b0, 2'b00, 4'd2, 16'h0000, 1'b1);
    chk("dr_after_ssr_do", do_dr, 16'h0077);
    chk("dr_after_ssr_valid", {15'd0, dv_dr}, 16'h0000);

    // SSR during write: output reset, write still lands
    step(1'b1, 1'b1, 2'b11, 4'd7, 16'h003C, 1'b1);
    chk("ssr_write_do", do_wf, 16'h5A5A);
    chk("ssr_write_valid", {15'd0, dv_wf}, 16'h0000);
    step(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, 1'b1);
    chk("ssr_write_readback", do_wf, 16'h003C);
    chk("ssr_write_rb_valid", {15'd0, dv_wf}, 16'h0001);

    // Reset mid-burst
    step(1'b1, 1'b0, 2'b11, 4'd10, 16'h1234, 1'b1);
    step(1'b1, 1'b0, 2'b11, 4'd11, 16'h5678, 1'b1);
    en = 1'b1; ssr = 1'b0; we = 2'b11; addr = 4'd12; di = 16'h9ABC; regce = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_do", do_wf, 16'h5A5A);
    chk("async_rst_valid", {15'd0, dv_wf}, 16'h0000);
    chk("async_rst_dr_do", do_dr, 16'h005A);
    addr = 4'd10; di = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_do", do_wf, 16'h5A5A);
    chk("rst_hold_valid", {15'd0, dv_wf}, 16'h0000);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2'b00, 4'd10, 16'h0000, 1'b1);
    chk("post_rst_a10", do_wf, 16'h1234);
    chk("post_rst_nc_a10", do_nc, 16'h1234);
    step(1'b1, 1'b0, 2'b00, 4'd11, 16'h0000, 1'b1);
    chk("post_rst_a11", do_wf, 16'h5678);
    step(1'b1, 1'b0, 2'b00, 4'd12, 16'h0000, 1'b1);
    chk("post_rst_a12", do_wf, 16'h0000);
    chk("post_rst_rf_a12", do_rf, 16'h1111);
    chk("post_rst_dr", do_dr, 16'h5678);
    step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
